v3a_free_list: RTL

Manages a pool of `p_num_entries` slot indices for the v3a queue datapath. It hands out free indices on an allocate port and takes back released indices on a free port. Indices live in a circular FIFO built on a 1-read/1-write storage array, and the block drives that array's read and write ports. It sits between the op-centric queue control, which allocates on enqueue and frees on dequeue, and the slot storage.

---
 rtl/v3a_free_list_pkg.sv | 10 +
 rtl/v3a_free_list_mem.sv | 34 +++
 rtl/v3a_free_list.sv | 102 ++++++++++
 3 files changed

// File: rtl/v3a_free_list_pkg.sv
// Shared types and default sizing for the v3a free list.
package v3a_free_list_pkg;

    localparam int P_NUM_ENTRIES = 8;
    localparam int P_IDX_WIDTH   = $clog2(P_NUM_ENTRIES);

    typedef logic [P_IDX_WIDTH-1:0] idx_t;
    typedef logic [P_IDX_WIDTH:0]   cnt_t;

endpackage

// File: rtl/v3a_free_list_mem.sv
// 1-read/1-write storage primitive; reset loads entry i with value i so the
// array starts out as an identity free list.
module v3a_free_list_mem
    import v3a_free_list_pkg::*;
#(
    parameter int  p_depth = P_NUM_ENTRIES,
    parameter type t_data  = idx_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_ren,
    input  logic [$clog2(p_depth)-1:0] i_raddr,
    output t_data                      o_rdata,
    input  logic                       i_we,
    input  logic [$clog2(p_depth)-1:0] i_waddr,
    input  t_data                      i_wdata
);

    t_data r_mem [p_depth];

    // Storage write port with identity initialisation on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_depth; i++) begin
                r_mem[i] <= t_data'(i);
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = i_ren ? r_mem[i_raddr] : t_data'(0);

endmodule

// File: rtl/v3a_free_list.sv
// Circular free list of slot indices: allocate from the head, return to the
// tail, with occupancy count and a sticky overflow flag.
module v3a_free_list
    import v3a_free_list_pkg::*;
#(
    parameter int p_num_entries = P_NUM_ENTRIES,
    parameter int p_idx_width   = $clog2(p_num_entries)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   alloc_val,
    input  logic                   alloc_rdy,
    output logic [p_idx_width-1:0] alloc_idx,
    input  logic                   free_val,
    output logic                   free_rdy,
    input  logic [p_idx_width-1:0] free_idx,
    output logic [p_idx_width:0]   num_free,
    output logic                   err_overflow
);

    localparam logic [p_idx_width:0]   LP_FULL    = (p_idx_width+1)'(p_num_entries);
    localparam logic [p_idx_width:0]   LP_CNT_ONE = (p_idx_width+1)'(1);
    localparam logic [p_idx_width-1:0] LP_PTR_ONE = p_idx_width'(1);

    logic [p_idx_width-1:0] r_head;
    logic [p_idx_width-1:0] r_tail;
    logic [p_idx_width:0]   r_count;
    logic                   r_err_overflow;

    logic                   w_nonempty;
    logic                   w_notfull;
    logic                   w_alloc_fire;
    logic                   w_free_fire;
    logic [p_idx_width-1:0] w_rdata;

    assign w_nonempty   = (r_count != {(p_idx_width+1){1'b0}});
    assign w_notfull    = (r_count != LP_FULL);
    // Handshakes presented during reset are dropped.
    assign w_alloc_fire = w_nonempty & alloc_rdy & ~reset;
    assign w_free_fire  = w_notfull & free_val & ~reset;

    v3a_free_list_mem #(
        .p_depth (p_num_entries),
        .t_data  (logic [p_idx_width-1:0])
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_ren   (w_nonempty),
        .i_raddr (r_head),
        .o_rdata (w_rdata),
        .i_we    (w_free_fire),
        .i_waddr (r_tail),
        .i_wdata (free_idx)
    );

    // Pointer, occupancy and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head         <= {p_idx_width{1'b0}};
            r_tail         <= {p_idx_width{1'b0}};
            r_count        <= LP_FULL;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_head <= r_head + LP_PTR_ONE;
            end
            if (w_free_fire) begin
                r_tail <= r_tail + LP_PTR_ONE;
            end
            case ({w_alloc_fire, w_free_fire})
                2'b10:   r_count <= r_count - LP_CNT_ONE;
                2'b01:   r_count <= r_count + LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (free_val && !w_notfull) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // Output view; while reset is high it already shows the post-reset state.
    always_comb begin
        alloc_val = 1'b1;
        alloc_idx = {p_idx_width{1'b0}};
        free_rdy  = 1'b0;
        num_free  = LP_FULL;
        if (reset) begin
            alloc_val = 1'b1;
            alloc_idx = {p_idx_width{1'b0}};
            free_rdy  = 1'b0;
            num_free  = LP_FULL;
        end else begin
            alloc_val = w_nonempty;
            alloc_idx = w_nonempty ? w_rdata : {p_idx_width{1'b0}};
            free_rdy  = w_notfull;
            num_free  = r_count;
        end
    end

    assign err_overflow = r_err_overflow;

endmodule
